// File: rtl/parity_frame_ctrl.sv
// Frame-aware serial parity receiver: start bit, N data bits LSB first, parity bit, stop bit.
// Each decoded frame is held in an output register under a valid/ack handshake with a sticky overrun flag.
module parity_frame_ctrl #(
   parameter int N   = 8,
   parameter bit ODD = 1'b0
) (
   input  logic         c,
   input  logic         r,
   input  logic         i,
   input  logic         en,
   input  logic         dack,
   output logic [N-1:0] dout,
   output logic         dvalid,
   output logic         perr,
   output logic         ferr,
   output logic         ovr,
   output logic         busy,
   output logic [1:0]   dbg_state
);
   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [N-1:0]  sh;
   logic          par;

   // A completed frame waits here for exactly one cycle before reaching the output register.
   logic          pend;
   logic [N-1:0]  pend_data;
   logic          pend_perr;
   logic          pend_ferr;

   assign dbg_state = state;

   always_ff @(posedge c or negedge r) begin
      if (!r) state <= IDLE;
      else    state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      if (en) begin
         unique case (state)
            IDLE:    if (!i) state_nx = DATA;
            DATA:    if (cnt == CW'(N - 1)) state_nx = PAR;
            PAR:     state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         cnt       <= '0;
         sh        <= '0;
         par       <= 1'b0;
         pend      <= 1'b0;
         pend_data <= '0;
         pend_perr <= 1'b0;
         pend_ferr <= 1'b0;
      end else begin
         pend <= 1'b0;
         if (en) begin
            unique case (state)
               IDLE: begin
                  cnt <= '0;
                  par <= 1'b0;
               end
               DATA: begin
                  sh  <= {i, sh[N-1:1]};
                  par <= par ^ i;
                  cnt <= cnt + 1'b1;
               end
               PAR: par <= par ^ i;
               STOP: begin
                  pend      <= 1'b1;
                  pend_data <= sh;
                  pend_perr <= par ^ ODD;
                  pend_ferr <= ~i;
               end
               default: ;
            endcase
         end
      end
   end

   // Handshake: dvalid marks dout/perr/ferr as held and stable; a cycle with dvalid=1 and
   // dack=1 consumes the result. A frame arriving while a result is held and not being
   // consumed is dropped and raises ovr, which clears on the next consuming cycle.
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         dout   <= '0;
         dvalid <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         ovr    <= 1'b0;
      end else if (pend && dvalid && !dack) begin
         ovr <= 1'b1;
      end else begin
         if (pend) begin
            dout   <= pend_data;
            perr   <= pend_perr;
            ferr   <= pend_ferr;
            dvalid <= 1'b1;
         end else if (dvalid && dack) begin
            dvalid <= 1'b0;
         end
         if (dvalid && dack) ovr <= 1'b0;
      end
   end
endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: an even and an odd parity instance share one serial line,
// checked by a table of frames, hand-written corner sequences and a randomized stream.
module tb_parity_frame_ctrl;
   localparam int N = 8;

   logic c = 1'b0;
   logic r = 1'b0;
   logic i = 1'b1;
   logic en = 1'b0;
   logic dack = 1'b0;

   logic [N-1:0] dout_e, dout_o;
   logic         dvalid_e, dvalid_o, perr_e, perr_o, ferr_e, ferr_o;
   logic         ovr_e, ovr_o, busy_e, busy_o;
   logic [1:0]   st_e, st_o;

   int n_vec = 0;
   int n_err = 0;

   parity_frame_ctrl #(.N(N), .ODD(1'b0)) dut_e (
      .c(c), .r(r), .i(i), .en(en), .dack(dack),
      .dout(dout_e), .dvalid(dvalid_e), .perr(perr_e), .ferr(ferr_e),
      .ovr(ovr_e), .busy(busy_e), .dbg_state(st_e)
   );

   parity_frame_ctrl #(.N(N), .ODD(1'b1)) dut_o (
      .c(c), .r(r), .i(i), .en(en), .dack(dack),
      .dout(dout_o), .dvalid(dvalid_o), .perr(perr_o), .ferr(ferr_o),
      .ovr(ovr_o), .busy(busy_o), .dbg_state(st_o)
   );

   always #5 c = ~c;

   // Reference model: bits of the frame in flight, plus the visible result registers.
   logic         mq[$];
   logic [N-1:0] m_dout, p_data;
   logic         m_dvalid, m_perr, m_perr_o, m_ferr, m_ovr;
   logic         m_pend, p_perr, p_perr_o, p_ferr;

   typedef struct {
      logic [7:0] data;
      logic       pbit;
      logic       stop;
      int         gap_at;
      int         gap_len;
      logic [7:0] exp_dout;
      logic       exp_perr;
      logic       exp_ferr;
      logic       exp_perr_o;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0; m_dvalid = 1'b0; m_perr = 1'b0; m_perr_o = 1'b0;
      m_ferr = 1'b0; m_ovr = 1'b0; m_pend = 1'b0;
      p_data = '0; p_perr = 1'b0; p_perr_o = 1'b0; p_ferr = 1'b0;
   endtask

   // Advances the model across one rising edge using the inputs currently driven.
   task automatic model_step();
      logic [N-1:0] d;
      int ones;
      if (!r) begin
         model_reset();
         return;
      end
      if (m_dvalid && dack) begin
         m_dvalid = 1'b0;
         m_ovr    = 1'b0;
      end
      if (m_pend) begin
         if (m_dvalid) m_ovr = 1'b1;
         else begin
            m_dout = p_data; m_perr = p_perr; m_perr_o = p_perr_o;
            m_ferr = p_ferr; m_dvalid = 1'b1;
         end
      end
      m_pend = 1'b0;
      if (en) begin
         if (mq.size() == 0) begin
            if (!i) mq.push_back(i);
         end else begin
            mq.push_back(i);
            if (mq.size() == N + 3) begin
               d = '0;
               for (int k = 0; k < N; k++) d[k] = mq[k + 1];
               ones     = $countones(d) + int'(mq[N + 1]);
               p_data   = d;
               p_perr   = (ones % 2) != 0;
               p_perr_o = (ones % 2) == 0;
               p_ferr   = !mq[N + 2];
               m_pend   = 1'b1;
               mq.delete();
            end
         end
      end
   endtask

   task automatic compare_all();
      check("dvalid", 32'(dvalid_e), 32'(m_dvalid));
      check("dout",   32'(dout_e),   32'(m_dout));
      check("perr",   32'(perr_e),   32'(m_perr));
      check("ferr",   32'(ferr_e),   32'(m_ferr));
      check("ovr",    32'(ovr_e),    32'(m_ovr));
      check("busy",   32'(busy_e),   32'(mq.size() != 0));
      check("odd_dvalid", 32'(dvalid_o), 32'(m_dvalid));
      check("odd_dout",   32'(dout_o),   32'(m_dout));
      check("odd_perr",   32'(perr_o),   32'(m_perr_o));
      check("odd_ferr",   32'(ferr_o),   32'(m_ferr));
      check("odd_ovr",    32'(ovr_o),    32'(m_ovr));
      check("odd_busy",   32'(busy_o),   32'(mq.size() != 0));
   endtask

   task automatic tick(input logic bi, input logic ben, input logic bdk);
      i = bi; en = ben; dack = bdk;
      model_step();
      @(negedge c);
      compare_all();
   endtask

   task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stop,
                             input int gap_at, input int gap_len, input logic dk);
      tick(1'b0, 1'b1, dk);
      for (int b = 0; b < N; b++) begin
         tick(data[b], 1'b1, dk);
         if (b + 1 == gap_at)
            for (int g = 0; g < gap_len; g++) tick(1'($urandom_range(0, 1)), 1'b0, dk);
      end
      tick(pbit, 1'b1, dk);
      tick(stop, 1'b1, dk);
   endtask

   initial begin
      tbl[0] = '{8'hA5, 1'b0, 1'b1, -1, 0, 8'hA5, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, -1, 0, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'hA5, 1'b0, 1'b0, -1, 0, 8'hA5, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{8'h3C, 1'b0, 1'b1,  4, 3, 8'h3C, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'h5A, 1'b0, 1'b1, -1, 0, 8'h5A, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{8'h01, 1'b0, 1'b1, -1, 0, 8'h01, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{8'h01, 1'b1, 1'b1, -1, 0, 8'h01, 1'b0, 1'b0, 1'b1};

      model_reset();
      @(negedge c);
      compare_all();
      r = 1'b1;
      tick(1'b1, 1'b1, 1'b0);

      foreach (tbl[k]) begin
         send_frame(tbl[k].data, tbl[k].pbit, tbl[k].stop, tbl[k].gap_at, tbl[k].gap_len, 1'b0);
         tick(1'b1, 1'b1, 1'b0);
         check("tbl_dvalid", 32'(dvalid_e), 32'd1);
         check("tbl_dout",   32'(dout_e),   32'(tbl[k].exp_dout));
         check("tbl_perr",   32'(perr_e),   32'(tbl[k].exp_perr));
         check("tbl_ferr",   32'(ferr_e),   32'(tbl[k].exp_ferr));
         check("tbl_perr_odd", 32'(perr_o), 32'(tbl[k].exp_perr_o));
         check("tbl_idle",   32'(busy_e),   32'd0);
         tick(1'b1, 1'b1, 1'b1);
         check("tbl_ack", 32'(dvalid_e), 32'd0);
      end

      // Overrun: second frame dropped while the first is still held.
      send_frame(8'h11, 1'b0, 1'b1, -1, 0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, -1, 0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      check("ovr_dout", 32'(dout_e), 32'h11);
      check("ovr_flag", 32'(ovr_e), 32'd1);
      tick(1'b1, 1'b1, 1'b1);
      check("ovr_clr_valid", 32'(dvalid_e), 32'd0);
      check("ovr_clr_flag", 32'(ovr_e), 32'd0);

      // Acknowledge on the load cycle of the second frame: it replaces the first.
      send_frame(8'h11, 1'b0, 1'b1, -1, 0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, -1, 0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      check("swap_dout", 32'(dout_e), 32'h22);
      check("swap_valid", 32'(dvalid_e), 32'd1);
      check("swap_ovr", 32'(ovr_e), 32'd0);
      tick(1'b1, 1'b1, 1'b1);

      // Reset mid-frame with a held result and overrun pending.
      send_frame(8'h11, 1'b0, 1'b1, -1, 0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, -1, 0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      for (int b = 0; b < 5; b++) tick(1'b1, 1'b1, 1'b0);
      r = 1'b0;
      #1;
      model_reset();
      check("rst_busy",   32'(busy_e),   32'd0);
      check("rst_dvalid", 32'(dvalid_e), 32'd0);
      check("rst_dout",   32'(dout_e),   32'd0);
      check("rst_ovr",    32'(ovr_e),    32'd0);
      @(negedge c);
      compare_all();
      r = 1'b1;
      tick(1'b1, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, -1, 0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      check("post_rst_dout", 32'(dout_e), 32'h5A);
      check("post_rst_perr", 32'(perr_e), 32'd0);
      tick(1'b1, 1'b1, 1'b1);

      // Randomized stream: arbitrary line bits, sparse strobes and acknowledges.
      for (int n = 0; n < 3000; n++)
         tick(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
